pc_ctrl: RTL

- Hazard and sequencing controller for the fetch stage of the 5-stage pipeline.
- Decides each cycle whether the PC register loads, and which next-PC source it takes: sequential, jump, branch or jr.
- Also drives IF/ID hold and flush, ID/EX bubble insertion, and a global pipeline freeze during memory waits.
- Sits between ID-stage decode, the EX/MEM pipeline registers and the PC register.

---
 rtl/pc_ctrl_pkg.sv | 54 +++++
 rtl/pc_ctrl_hazard.sv | 38 +++
 rtl/pc_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage controller: FSM encoding, next-PC select codes
// (also used by the PC register and datapath) and the control-output presets.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HAZ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_BEQ  = 2'b10;
  localparam logic [1:0] PCSRC_JR   = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       pipe_freeze;
  } ctl_t;

  localparam ctl_t CTL_RUN = '{pc_write: 1'b1, pc_src: PCSRC_SEQ, ifid_write: 1'b1,
                               ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_freeze: 1'b0};

  localparam ctl_t CTL_STALL = '{pc_write: 1'b0, pc_src: PCSRC_SEQ, ifid_write: 1'b0,
                                 ifid_flush: 1'b0, idex_bubble: 1'b1, pipe_freeze: 1'b0};

  localparam ctl_t CTL_FREEZE = '{pc_write: 1'b0, pc_src: PCSRC_SEQ, ifid_write: 1'b0,
                                  ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_freeze: 1'b1};

  localparam ctl_t CTL_RESET = '{pc_write: 1'b0, pc_src: PCSRC_SEQ, ifid_write: 1'b0,
                                 ifid_flush: 1'b1, idex_bubble: 1'b1, pipe_freeze: 1'b0};

  // jr beats beq beats j; any redirect squashes the instruction just fetched.
  function automatic ctl_t redirect_ctl(input logic jr, input logic beq, input logic jmp);
    ctl_t c;
    c = CTL_RUN;
    if (jr) begin
      c.pc_src     = PCSRC_JR;
      c.ifid_flush = 1'b1;
    end else if (beq) begin
      c.pc_src     = PCSRC_BEQ;
      c.ifid_flush = 1'b1;
    end else if (jmp) begin
      c.pc_src     = PCSRC_JUMP;
      c.ifid_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pc_ctrl_hazard.sv
// hazard_detect: combinational load-use and jr-operand hazard detection for the ID stage.
// jr_stall_n is the number of stall cycles the jr needs before its rs value is usable.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jr,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  output logic             load_use,
  output logic [1:0]       jr_stall_n
);

  logic ex_hits_rs;
  logic ex_hits_rt;

  assign ex_hits_rs = (ex_rd == id_rs);
  assign ex_hits_rt = id_uses_rt && (ex_rd == id_rt);

  always_comb begin
    load_use   = ex_memread && (ex_rd != '0) && (ex_hits_rs || ex_hits_rt);
    jr_stall_n = 2'd0;
    // jr resolves in ID, so it must wait for a load two stages out, or any writer one stage out.
    if (id_jr && (id_rs != '0)) begin
      if (ex_memread && ex_hits_rs) begin
        jr_stall_n = 2'd2;
      end else if ((ex_regwrite && ex_hits_rs) || (mem_memread && (mem_rd == id_rs))) begin
        jr_stall_n = 2'd1;
      end
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage hazard/sequencing controller (PC load, next-PC select, IF/ID hold/flush,
// ID/EX bubble, global freeze). Define PC_CTRL_PERF_EN to add stall/flush performance counters.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wait,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              id_jr,
  input  logic              id_branch_taken,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              mem_memread,
  input  logic [REG_W-1:0]  mem_rd,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  if (PERF_W < 1) begin : g_perf_w_check
    $error("pc_ctrl: PERF_W must be at least 1");
  end

  logic       load_use;
  logic [1:0] jr_stall_n;
  logic       stall_req;
  state_e     state;
  state_e     state_nxt;
  state_e     saved_state;
  state_e     saved_nxt;
  state_e     eff_state;
  logic [1:0] stall_cnt;
  logic [1:0] stall_cnt_nxt;
  ctl_t       ctl;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_jr       (id_jr),
    .ex_memread  (ex_memread),
    .ex_regwrite (ex_regwrite),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .load_use    (load_use),
    .jr_stall_n  (jr_stall_n)
  );

  assign stall_req = load_use || (jr_stall_n != 2'd0);

  // Leaving WAIT behaves exactly like the state that was interrupted.
  assign eff_state = (state == WAIT) ? saved_state : state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      saved_state <= RUN;
      stall_cnt   <= 2'd0;
    end else begin
      state       <= state_nxt;
      saved_state <= saved_nxt;
      stall_cnt   <= stall_cnt_nxt;
    end
  end

  always_comb begin
    ctl           = CTL_RUN;
    state_nxt     = state;
    saved_nxt     = saved_state;
    stall_cnt_nxt = stall_cnt;
    if (rst) begin
      ctl = CTL_RESET;
    end else if (mem_wait) begin
      ctl = CTL_FREEZE;
      if (state != WAIT) begin
        saved_nxt = state;
        state_nxt = WAIT;
      end
    end else begin
      case (eff_state)
        HAZ: begin
          // The held instruction is not re-examined; just count down the remaining stalls.
          ctl           = CTL_STALL;
          stall_cnt_nxt = stall_cnt - 2'd1;
          if (stall_cnt <= 2'd1) begin
            state_nxt = RUN;
          end else begin
            state_nxt = HAZ;
          end
        end
        default: begin
          state_nxt = RUN;
          if (stall_req) begin
            ctl = CTL_STALL;
            if (jr_stall_n > 2'd1) begin
              stall_cnt_nxt = jr_stall_n - 2'd1;
              state_nxt     = HAZ;
            end
          end else begin
            ctl = redirect_ctl(id_jr, id_branch_taken, id_jump);
          end
        end
      endcase
    end
  end

  assign pc_write    = ctl.pc_write;
  assign pc_src      = ctl.pc_src;
  assign ifid_write  = ctl.ifid_write;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_bubble = ctl.idex_bubble;
  assign pipe_freeze = ctl.pipe_freeze;

`ifdef PC_CTRL_PERF_EN
  // Frozen cycles are not counted: the pipeline did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else if (!pipe_freeze) begin
      if (idex_bubble) begin
        perf_stall <= perf_stall + 1'b1;
      end
      if (ifid_flush) begin
        perf_flush <= perf_flush + 1'b1;
      end
    end
  end
`endif

endmodule
